// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcodes, ALU codes, sequencer states and the control-word layout.
// The optional undefined-opcode trap is selected by CU_ILLEGAL_TRAP_EN in control_sequencer.
package cpu_pkg;

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADDI = 5'b01100;
    localparam logic [4:0] OP_ANDI = 5'b01101;
    localparam logic [4:0] OP_ORI  = 5'b01110;
    localparam logic [4:0] OP_BR   = 5'b10010;
    localparam logic [4:0] OP_JR   = 5'b10011;
    localparam logic [4:0] OP_JAL  = 5'b10100;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    localparam logic [4:0] ALU_NONE = 5'b00000;
    localparam logic [4:0] ALU_ADD  = 5'b00001;
    localparam logic [4:0] ALU_AND  = 5'b00101;
    localparam logic [4:0] ALU_OR   = 5'b00110;

    // One state per control step; shared steps are split per opcode so outputs stay a pure state decode.
    typedef enum logic [4:0] {
        S_IDLE, S_F0, S_F1, S_F2, S_HALT,
        S_LDI_T3, S_LDI_T4, S_LDI_T5,
        S_LD_T3, S_LD_T4, S_LD_T5, S_LD_T6, S_LD_T7,
        S_ST_T3, S_ST_T4, S_ST_T5, S_ST_T6, S_ST_T7,
        S_ADDI_T3, S_ADDI_T4, S_ANDI_T3, S_ANDI_T4, S_ORI_T3, S_ORI_T4, S_IMM_T5,
        S_BR_T3, S_BR_T4, S_BR_T5, S_BR_T6,
        S_JR_T3, S_JAL_T3, S_JAL_T4
    } state_t;

    typedef struct packed {
        logic pc_enable;
        logic pc_increment_enable;
        logic ir_enable;
        logic y_enable;
        logic z_enable;
        logic mar_enable;
        logic mdr_enable;
        logic r_enable;
        logic con_enable;
        logic manual_r15_enable;
        logic read;
        logic write;
        logic gra;
        logic grb;
        logic ba_select;
        logic pc_select;
        logic z_lo_select;
        logic mdr_select;
        logic c_select;
        logic r_select;
    } ctrl_t;

    function automatic logic is_last_step(input state_t s);
        return (s == S_LDI_T5) || (s == S_LD_T7) || (s == S_ST_T7) || (s == S_IMM_T5) ||
               (s == S_BR_T6) || (s == S_JR_T3) || (s == S_JAL_T4);
    endfunction

endpackage

// File: rtl/control_decode.sv
// Combinational decode of the sequencer state into the datapath control word and ALU opcode.
// con_output reaches PC_enable only in the final branch step.
module control_decode
    import cpu_pkg::*;
(
    input  state_t      state,
    input  logic        con_output,
    output ctrl_t       ctrl,
    output logic [4:0]  alu_instruction
);

    always_comb begin
        ctrl            = '0;
        alu_instruction = ALU_NONE;
        case (state)
            S_F0: begin
                ctrl.pc_select  = 1'b1;
                ctrl.mar_enable = 1'b1;
            end
            S_F1: begin
                ctrl.pc_increment_enable = 1'b1;
                ctrl.read                = 1'b1;
                ctrl.mdr_enable          = 1'b1;
            end
            S_F2: begin
                ctrl.mdr_select = 1'b1;
                ctrl.ir_enable  = 1'b1;
            end
            S_LDI_T3, S_LD_T3, S_ST_T3: begin
                ctrl.grb       = 1'b1;
                ctrl.ba_select = 1'b1;
                ctrl.y_enable  = 1'b1;
            end
            S_LDI_T4, S_LD_T4, S_ST_T4, S_ADDI_T4, S_BR_T5: begin
                ctrl.c_select   = 1'b1;
                ctrl.z_enable   = 1'b1;
                alu_instruction = ALU_ADD;
            end
            S_ANDI_T4: begin
                ctrl.c_select   = 1'b1;
                ctrl.z_enable   = 1'b1;
                alu_instruction = ALU_AND;
            end
            S_ORI_T4: begin
                ctrl.c_select   = 1'b1;
                ctrl.z_enable   = 1'b1;
                alu_instruction = ALU_OR;
            end
            S_LDI_T5, S_IMM_T5: begin
                ctrl.z_lo_select = 1'b1;
                ctrl.gra         = 1'b1;
                ctrl.r_enable    = 1'b1;
            end
            S_LD_T5, S_ST_T5: begin
                ctrl.z_lo_select = 1'b1;
                ctrl.mar_enable  = 1'b1;
            end
            S_LD_T6: begin
                ctrl.read       = 1'b1;
                ctrl.mdr_enable = 1'b1;
            end
            S_LD_T7: begin
                ctrl.mdr_select = 1'b1;
                ctrl.gra        = 1'b1;
                ctrl.r_enable   = 1'b1;
            end
            S_ST_T6: begin
                ctrl.gra        = 1'b1;
                ctrl.r_select   = 1'b1;
                ctrl.mdr_enable = 1'b1;
            end
            S_ST_T7: begin
                ctrl.write = 1'b1;
            end
            S_ADDI_T3, S_ANDI_T3, S_ORI_T3: begin
                ctrl.grb      = 1'b1;
                ctrl.r_select = 1'b1;
                ctrl.y_enable = 1'b1;
            end
            S_BR_T3: begin
                ctrl.gra        = 1'b1;
                ctrl.r_select   = 1'b1;
                ctrl.con_enable = 1'b1;
            end
            S_BR_T4: begin
                ctrl.pc_select = 1'b1;
                ctrl.y_enable  = 1'b1;
            end
            S_BR_T6: begin
                ctrl.z_lo_select = 1'b1;
                ctrl.pc_enable   = con_output;
            end
            S_JR_T3, S_JAL_T4: begin
                ctrl.gra       = 1'b1;
                ctrl.r_select  = 1'b1;
                ctrl.pc_enable = 1'b1;
            end
            S_JAL_T3: begin
                ctrl.manual_r15_enable = 1'b1;
                ctrl.pc_select         = 1'b1;
            end
            default: begin
                ctrl            = '0;
                alu_instruction = ALU_NONE;
            end
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// Moore control sequencer: fetch F0-F2, opcode decode, execute steps, retired-instruction counter.
// Define CU_ILLEGAL_TRAP_EN to halt and flag undefined opcodes instead of treating them as NOP.
module control_sequencer
    import cpu_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic [31:0]      IR_Data,
    input  logic             con_output,
    output logic             PC_enable,
    output logic             PC_increment_enable,
    output logic             IR_enable,
    output logic             Y_enable,
    output logic             Z_enable,
    output logic             MAR_enable,
    output logic             MDR_enable,
    output logic             r_enable,
    output logic             con_enable,
    output logic             manual_R15_enable,
    output logic             read,
    output logic             write,
    output logic             Gra,
    output logic             Grb,
    output logic             ba_select,
    output logic             PC_select,
    output logic             Z_LO_select,
    output logic             MDR_select,
    output logic             c_select,
    output logic             r_select,
    output logic [4:0]       alu_instruction,
    output logic             halted,
    output logic             illegal_op,
    output logic [CNT_W-1:0] instr_count
);

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] count_reg;
    logic             retire;
    logic [4:0]       opcode;
    logic             unused_ir;
    ctrl_t            ctrl;

    assign opcode    = IR_Data[31:27];
    assign unused_ir = ^IR_Data[26:0];

`ifdef CU_ILLEGAL_TRAP_EN
    logic illegal_reg;
    logic trap;
`endif

    always_comb begin
        state_next = state_reg;
        retire     = 1'b0;
`ifdef CU_ILLEGAL_TRAP_EN
        trap       = 1'b0;
`endif
        if (is_last_step(state_reg)) begin
            retire     = 1'b1;
            state_next = run ? S_F0 : S_IDLE;
        end else begin
            case (state_reg)
                S_IDLE:    state_next = run ? S_F0 : S_IDLE;
                S_F0:      state_next = S_F1;
                S_F1:      state_next = S_F2;
                S_F2: begin
                    case (opcode)
                        OP_LD:   state_next = S_LD_T3;
                        OP_LDI:  state_next = S_LDI_T3;
                        OP_ST:   state_next = S_ST_T3;
                        OP_ADDI: state_next = S_ADDI_T3;
                        OP_ANDI: state_next = S_ANDI_T3;
                        OP_ORI:  state_next = S_ORI_T3;
                        OP_BR:   state_next = S_BR_T3;
                        OP_JR:   state_next = S_JR_T3;
                        OP_JAL:  state_next = S_JAL_T3;
                        OP_NOP: begin
                            retire     = 1'b1;
                            state_next = run ? S_F0 : S_IDLE;
                        end
                        OP_HALT: begin
                            retire     = 1'b1;
                            state_next = S_HALT;
                        end
                        default: begin
`ifdef CU_ILLEGAL_TRAP_EN
                            trap       = 1'b1;
                            state_next = S_HALT;
`else
                            retire     = 1'b1;
                            state_next = run ? S_F0 : S_IDLE;
`endif
                        end
                    endcase
                end
                S_LDI_T3:  state_next = S_LDI_T4;
                S_LDI_T4:  state_next = S_LDI_T5;
                S_LD_T3:   state_next = S_LD_T4;
                S_LD_T4:   state_next = S_LD_T5;
                S_LD_T5:   state_next = S_LD_T6;
                S_LD_T6:   state_next = S_LD_T7;
                S_ST_T3:   state_next = S_ST_T4;
                S_ST_T4:   state_next = S_ST_T5;
                S_ST_T5:   state_next = S_ST_T6;
                S_ST_T6:   state_next = S_ST_T7;
                S_ADDI_T3: state_next = S_ADDI_T4;
                S_ANDI_T3: state_next = S_ANDI_T4;
                S_ORI_T3:  state_next = S_ORI_T4;
                S_ADDI_T4, S_ANDI_T4, S_ORI_T4: state_next = S_IMM_T5;
                S_BR_T3:   state_next = S_BR_T4;
                S_BR_T4:   state_next = S_BR_T5;
                S_BR_T5:   state_next = S_BR_T6;
                S_JAL_T3:  state_next = S_JAL_T4;
                S_HALT:    state_next = S_HALT;
                default:   state_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= S_IDLE;
            count_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (retire) begin
                count_reg <= count_reg + 1'b1;
            end
        end
    end

`ifdef CU_ILLEGAL_TRAP_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            illegal_reg <= 1'b0;
        end else if (trap) begin
            illegal_reg <= 1'b1;
        end
    end
    assign illegal_op = illegal_reg;
`else
    assign illegal_op = 1'b0;
`endif

    control_decode u_decode (
        .state           (state_reg),
        .con_output      (con_output),
        .ctrl            (ctrl),
        .alu_instruction (alu_instruction)
    );

    assign PC_enable           = ctrl.pc_enable;
    assign PC_increment_enable = ctrl.pc_increment_enable;
    assign IR_enable           = ctrl.ir_enable;
    assign Y_enable            = ctrl.y_enable;
    assign Z_enable            = ctrl.z_enable;
    assign MAR_enable          = ctrl.mar_enable;
    assign MDR_enable          = ctrl.mdr_enable;
    assign r_enable            = ctrl.r_enable;
    assign con_enable          = ctrl.con_enable;
    assign manual_R15_enable   = ctrl.manual_r15_enable;
    assign read                = ctrl.read;
    assign write               = ctrl.write;
    assign Gra                 = ctrl.gra;
    assign Grb                 = ctrl.grb;
    assign ba_select           = ctrl.ba_select;
    assign PC_select           = ctrl.pc_select;
    assign Z_LO_select         = ctrl.z_lo_select;
    assign MDR_select          = ctrl.mdr_select;
    assign c_select            = ctrl.c_select;
    assign r_select            = ctrl.r_select;
    assign halted              = (state_reg == S_HALT);
    assign instr_count         = count_reg;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed self-checking bench for control_sequencer; expected control words are hand-built constants.
// Undefined-opcode expectations follow CU_ILLEGAL_TRAP_EN.
module tb_control_sequencer;
    import cpu_pkg::*;

    logic        clk = 1'b0;
    logic        reset, run, con_output;
    logic [31:0] IR_Data;
    logic PC_enable, PC_increment_enable, IR_enable, Y_enable, Z_enable, MAR_enable, MDR_enable;
    logic r_enable, con_enable, manual_R15_enable, read, write, Gra, Grb, ba_select, PC_select;
    logic Z_LO_select, MDR_select, c_select, r_select, halted, illegal_op;
    logic [4:0]  alu_instruction;
    logic [31:0] instr_count;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    control_sequencer #(.CNT_W(32)) dut (
        .clk(clk), .reset(reset), .run(run), .IR_Data(IR_Data), .con_output(con_output),
        .PC_enable(PC_enable), .PC_increment_enable(PC_increment_enable), .IR_enable(IR_enable),
        .Y_enable(Y_enable), .Z_enable(Z_enable), .MAR_enable(MAR_enable), .MDR_enable(MDR_enable),
        .r_enable(r_enable), .con_enable(con_enable), .manual_R15_enable(manual_R15_enable),
        .read(read), .write(write), .Gra(Gra), .Grb(Grb), .ba_select(ba_select),
        .PC_select(PC_select), .Z_LO_select(Z_LO_select), .MDR_select(MDR_select),
        .c_select(c_select), .r_select(r_select), .alu_instruction(alu_instruction),
        .halted(halted), .illegal_op(illegal_op), .instr_count(instr_count)
    );

    localparam logic [19:0] PCEN = 20'h80000, PCINC = 20'h40000, IREN = 20'h20000, YEN = 20'h10000;
    localparam logic [19:0] ZEN = 20'h08000, MAREN = 20'h04000, MDREN = 20'h02000, REN = 20'h01000;
    localparam logic [19:0] CONEN = 20'h00800, R15 = 20'h00400, RD = 20'h00200, WR = 20'h00100;
    localparam logic [19:0] GRA = 20'h00080, GRB = 20'h00040, BA = 20'h00020, PCSEL = 20'h00010;
    localparam logic [19:0] ZLO = 20'h00008, MDRSEL = 20'h00004, CSEL = 20'h00002, RSEL = 20'h00001;
    localparam logic [19:0] NONE  = 20'h00000;
    localparam logic [19:0] C_F0  = PCSEL | MAREN;
    localparam logic [19:0] C_F1  = PCINC | RD | MDREN;
    localparam logic [19:0] C_F2  = MDRSEL | IREN;
    localparam logic [19:0] C_M3  = GRB | BA | YEN;
    localparam logic [19:0] C_A4  = CSEL | ZEN;
    localparam logic [19:0] C_WB5 = ZLO | GRA | REN;
    localparam logic [19:0] C_MA5 = ZLO | MAREN;
    localparam logic [4:0]  A0 = 5'd0, AADD = 5'b00001, AAND = 5'b00101, AOR = 5'b00110;

    function automatic logic [19:0] ctl_word();
        return {PC_enable, PC_increment_enable, IR_enable, Y_enable, Z_enable, MAR_enable,
                MDR_enable, r_enable, con_enable, manual_R15_enable, read, write, Gra, Grb,
                ba_select, PC_select, Z_LO_select, MDR_select, c_select, r_select};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reset, then release with run high so the next edge enters F0.
    task automatic start_instr(input logic [31:0] ir);
        reset = 1'b1; run = 1'b1; IR_Data = ir;
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1; run = 1'b1; IR_Data = 32'h08800055; con_output = 1'b0;
        tick();
        tick();
        checks++;
        if (ctl_word() !== NONE || alu_instruction !== A0 || instr_count !== 32'd0 ||
            halted !== 1'b0 || illegal_op !== 1'b0) begin
            failures++;
            $display("FAIL reset: ctl=%h alu=%h cnt=%0d halted=%b ill=%b, expected all zero",
                     ctl_word(), alu_instruction, instr_count, halted, illegal_op);
        end
    endtask

    task automatic test_ldi();
        logic [19:0] ec [7];
        logic [4:0]  ea [7];
        ec = '{C_F0, C_F1, C_F2, C_M3, C_A4, C_WB5, C_F0};
        ea = '{A0, A0, A0, A0, AADD, A0, A0};
        start_instr(32'h08800055);
        for (int i = 0; i < 7; i++) begin
            checks++;
            if (ctl_word() !== ec[i] || alu_instruction !== ea[i]) begin
                failures++;
                $display("FAIL ldi step %0d: ctl=%h alu=%h expected ctl=%h alu=%h",
                         i, ctl_word(), alu_instruction, ec[i], ea[i]);
            end
            if (i == 5) begin
                checks++;
                if (instr_count !== 32'd0) begin
                    failures++;
                    $display("FAIL ldi_count_t5: got %0d expected 0", instr_count);
                end
            end
            if (i < 6) tick();
        end
        checks++;
        if (instr_count !== 32'd1) begin
            failures++;
            $display("FAIL ldi_count: got %0d expected 1", instr_count);
        end
    endtask

    task automatic test_alu_imm();
        logic [4:0]  ops [3];
        logic [4:0]  alus [3];
        logic [19:0] ec [7];
        ops  = '{OP_ADDI, OP_ANDI, OP_ORI};
        alus = '{AADD, AAND, AOR};
        ec   = '{C_F0, C_F1, C_F2, GRB | RSEL | YEN, C_A4, C_WB5, NONE};
        for (int k = 0; k < 3; k++) begin
            start_instr({ops[k], 27'h0123456});
            run = 1'b0;
            for (int i = 0; i < 7; i++) begin
                checks++;
                if (ctl_word() !== ec[i] || alu_instruction !== ((i == 4) ? alus[k] : A0)) begin
                    failures++;
                    $display("FAIL alu_imm op=%b step %0d: ctl=%h alu=%h expected ctl=%h",
                             ops[k], i, ctl_word(), alu_instruction, ec[i]);
                end
                if (i < 6) tick();
            end
            checks++;
            if (instr_count !== 32'd1) begin
                failures++;
                $display("FAIL alu_imm_count op=%b: got %0d expected 1", ops[k], instr_count);
            end
        end
    endtask

    task automatic test_jal();
        logic [19:0] ec [6];
        ec = '{C_F0, C_F1, C_F2, R15 | PCSEL, GRA | RSEL | PCEN, C_F0};
        start_instr({OP_JAL, 27'h1000000});
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (ctl_word() !== ec[i] || alu_instruction !== A0) begin
                failures++;
                $display("FAIL jal step %0d: ctl=%h alu=%h expected ctl=%h alu=0",
                         i, ctl_word(), alu_instruction, ec[i]);
            end
            if (i < 5) tick();
        end
    endtask

    task automatic test_br();
        logic [19:0] ec [8];
        for (int c = 0; c < 2; c++) begin
            con_output = c[0];
            ec = '{C_F0, C_F1, C_F2, GRA | RSEL | CONEN, PCSEL | YEN, C_A4,
                   ZLO | (c[0] ? PCEN : NONE), C_F0};
            start_instr({OP_BR, 27'h0400010});
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (ctl_word() !== ec[i] || alu_instruction !== ((i == 5) ? AADD : A0)) begin
                    failures++;
                    $display("FAIL br con=%0d step %0d: ctl=%h alu=%h expected ctl=%h",
                             c, i, ctl_word(), alu_instruction, ec[i]);
                end
                if (i < 7) tick();
            end
            checks++;
            if (instr_count !== 32'd1) begin
                failures++;
                $display("FAIL br_count con=%0d: got %0d expected 1", c, instr_count);
            end
        end
        con_output = 1'b0;
    endtask

    task automatic test_st();
        logic [19:0] ec [9];
        ec = '{C_F0, C_F1, C_F2, C_M3, C_A4, C_MA5, GRA | RSEL | MDREN, WR, NONE};
        start_instr({OP_ST, 27'h0800020});
        run = 1'b0;
        for (int i = 0; i < 9; i++) begin
            checks++;
            if (ctl_word() !== ec[i]) begin
                failures++;
                $display("FAIL st step %0d: ctl=%h expected %h", i, ctl_word(), ec[i]);
            end
            if (i < 8) tick();
        end
        checks++;
        if (instr_count !== 32'd1) begin
            failures++;
            $display("FAIL st_count: got %0d expected 1", instr_count);
        end
    endtask

    task automatic test_ld();
        logic [19:0] ec [9];
        ec = '{C_F0, C_F1, C_F2, C_M3, C_A4, C_MA5, RD | MDREN, MDRSEL | GRA | REN, C_F0};
        start_instr({OP_LD, 27'h0800020});
        for (int i = 0; i < 9; i++) begin
            checks++;
            if (ctl_word() !== ec[i]) begin
                failures++;
                $display("FAIL ld step %0d: ctl=%h expected %h", i, ctl_word(), ec[i]);
            end
            if (i < 8) tick();
        end
    endtask

    task automatic test_reset_mid_ld();
        start_instr({OP_LD, 27'h0800020});
        for (int i = 0; i < 5; i++) tick();
        checks++;
        if (ctl_word() !== C_MA5) begin
            failures++;
            $display("FAIL mid_ld_t5: ctl=%h expected %h", ctl_word(), C_MA5);
        end
        reset = 1'b1;
        tick();
        checks++;
        if (ctl_word() !== NONE || alu_instruction !== A0 || instr_count !== 32'd0) begin
            failures++;
            $display("FAIL mid_ld_reset: ctl=%h alu=%h cnt=%0d expected all zero",
                     ctl_word(), alu_instruction, instr_count);
        end
        reset = 1'b0;
        run   = 1'b0;
        tick();
        checks++;
        if (ctl_word() !== NONE) begin
            failures++;
            $display("FAIL mid_ld_idle: ctl=%h expected 0", ctl_word());
        end
    endtask

    task automatic test_back_to_back();
        logic [19:0] ec [8];
        ec = '{C_F0, C_F1, C_F2, GRA | RSEL | PCEN, C_F0, C_F1, C_F2, C_F0};
        start_instr({OP_JR, 27'h0200000});
        for (int i = 0; i < 8; i++) begin
            if (i == 4) IR_Data = {OP_NOP, 27'h0};
            checks++;
            if (ctl_word() !== ec[i]) begin
                failures++;
                $display("FAIL b2b step %0d: ctl=%h expected %h", i, ctl_word(), ec[i]);
            end
            if (i < 7) tick();
        end
        checks++;
        if (instr_count !== 32'd2) begin
            failures++;
            $display("FAIL b2b_count: got %0d expected 2", instr_count);
        end
    endtask

    task automatic test_halt();
        start_instr({OP_HALT, 27'h0});
        for (int i = 0; i < 3; i++) tick();
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (halted !== 1'b1 || ctl_word() !== NONE || instr_count !== 32'd1 || illegal_op !== 1'b0) begin
                failures++;
                $display("FAIL halt cycle %0d: halted=%b ctl=%h cnt=%0d ill=%b expected 1/0/1/0",
                         i, halted, ctl_word(), instr_count, illegal_op);
            end
            tick();
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        run   = 1'b0;
        checks++;
        if (halted !== 1'b0 || instr_count !== 32'd0) begin
            failures++;
            $display("FAIL halt_reset: halted=%b cnt=%0d expected 0/0", halted, instr_count);
        end
    endtask

    task automatic test_illegal();
        start_instr({5'b11111, 27'h0});
        run = 1'b0;
        for (int i = 0; i < 3; i++) tick();
`ifdef CU_ILLEGAL_TRAP_EN
        run = 1'b1;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (halted !== 1'b1 || illegal_op !== 1'b1 || instr_count !== 32'd0 || ctl_word() !== NONE) begin
                failures++;
                $display("FAIL illegal_trap cycle %0d: halted=%b ill=%b cnt=%0d ctl=%h expected 1/1/0/0",
                         i, halted, illegal_op, instr_count, ctl_word());
            end
            tick();
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        run   = 1'b0;
        checks++;
        if (illegal_op !== 1'b0 || halted !== 1'b0) begin
            failures++;
            $display("FAIL illegal_clear: ill=%b halted=%b expected 0/0", illegal_op, halted);
        end
`else
        checks++;
        if (halted !== 1'b0 || illegal_op !== 1'b0 || instr_count !== 32'd1 || ctl_word() !== NONE) begin
            failures++;
            $display("FAIL illegal_nop: halted=%b ill=%b cnt=%0d ctl=%h expected 0/0/1/0",
                     halted, illegal_op, instr_count, ctl_word());
        end
`endif
    endtask

    initial begin
        reset = 1'b1; run = 1'b0; con_output = 1'b0; IR_Data = 32'h0;
        test_reset();
        test_ldi();
        test_alu_imm();
        test_jal();
        test_br();
        test_st();
        test_ld();
        test_reset_mid_ld();
        test_back_to_back();
        test_halt();
        test_illegal();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
